// File: rtl/d_flip_flop.sv
// Parameterizable rising-edge register with asynchronous active-high reset
// and a complementary output. Each bit is an independent storage cell.

module d_flip_flop_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= RESET_VALUE;
    else       q <= d;
  end
endmodule

module d_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);
  logic [WIDTH-1:0] state;

  // One cell per bit; q[i] depends only on d[i].
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_flip_flop_bit #(.RESET_VALUE(RESET_VALUE[i])) u_bit (
      .clk   (clk),
      .reset (reset),
      .d     (d[i]),
      .q     (state[i])
    );
  end

  assign q  = state;
  assign qn = ~state;
endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench: 1-bit instance (reset 0) and 8-bit instance (reset A5)
// sharing one 20 ns clock that starts high.
`timescale 1ns/1ps

module tb_d_flip_flop;
  logic       clk = 1'b1;
  logic       reset1, reset8;
  logic       d1;
  logic [7:0] d8;
  logic       q1, qn1;
  logic [7:0] q8, qn8;
  int passed = 0;
  int total  = 0;

  always #10 clk = ~clk;

  d_flip_flop #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset1), .d(d1), .q(q1), .qn(qn1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk(clk), .reset(reset8), .d(d8), .q(q8), .qn(qn8)
  );

  task automatic test_reset;
    // q stays 0 across three clock edges while d toggles underneath.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); d1 = ~d1; d8 = ~d8;
      #5;
      total++;
      if ({q1, qn1} !== 2'b01) $display("FAIL reset_low c%0d q/qn=%b%b want 01", i, q1, qn1);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({q1, qn1} !== 2'b01) $display("FAIL reset_edge c%0d q/qn=%b%b want 01", i, q1, qn1);
      else passed++;
      total++;
      if ({q8, qn8} !== 16'hA55A) $display("FAIL reset_wide c%0d q/qn=%h/%h want a5/5a", i, q8, qn8);
      else passed++;
    end
  endtask

  task automatic test_capture;
    logic seq [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic prev;
    @(negedge clk); reset1 = 1'b0; d1 = 1'b0;
    @(posedge clk); #1;
    prev = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); d1 = seq[i];
      #1;
      total++;
      if ({q1, qn1} !== {prev, ~prev}) $display("FAIL cap_hold s%0d q/qn=%b%b want %b%b", i, q1, qn1, prev, ~prev);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({q1, qn1} !== {seq[i], ~seq[i]}) $display("FAIL cap_edge s%0d q/qn=%b%b want %b%b", i, q1, qn1, seq[i], ~seq[i]);
      else passed++;
      prev = seq[i];
    end
  endtask

  task automatic test_hold;
    // q is 0 here; a 5 ns high pulse and an X on d inside the low phase must not show.
    @(negedge clk); d1 = 1'b0;
    #2 d1 = 1'b1;
    #2;
    total++;
    if (q1 !== 1'b0) $display("FAIL hold_pulse q=%b want 0", q1);
    else passed++;
    #3 d1 = 1'b0;
    #1 d1 = 1'bx;
    #1;
    total++;
    if ({q1, qn1} !== 2'b01) $display("FAIL hold_x q/qn=%b%b want 01", q1, qn1);
    else passed++;
    d1 = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({q1, qn1} !== 2'b01) $display("FAIL hold_edge q/qn=%b%b want 01", q1, qn1);
    else passed++;
  endtask

  task automatic test_async_reset;
    @(negedge clk); d1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (q1 !== 1'b1) $display("FAIL ar_setup q=%b want 1", q1);
    else passed++;
    #2 reset1 = 1'b1;
    #0.1;
    total++;
    if ({q1, qn1} !== 2'b01) $display("FAIL ar_immediate q/qn=%b%b want 01", q1, qn1);
    else passed++;
    // Release just after the edge: that edge sees reset and must not capture.
    @(posedge clk); #1 reset1 = 1'b0;
    @(negedge clk);
    total++;
    if ({q1, qn1} !== 2'b01) $display("FAIL ar_release_edge q/qn=%b%b want 01", q1, qn1);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({q1, qn1} !== 2'b10) $display("FAIL ar_first_capture q/qn=%b%b want 10", q1, qn1);
    else passed++;
  endtask

  task automatic test_wide;
    @(negedge clk);
    total++;
    if ({q8, qn8} !== 16'hA55A) $display("FAIL wide_reset q/qn=%h/%h want a5/5a", q8, qn8);
    else passed++;
    reset8 = 1'b0; d8 = 8'h3C;
    @(posedge clk); #1;
    total++;
    if ({q8, qn8} !== 16'h3CC3) $display("FAIL wide_3c q/qn=%h/%h want 3c/c3", q8, qn8);
    else passed++;
    @(negedge clk); d8 = 8'hFF;
    #1;
    total++;
    if (q8 !== 8'h3C) $display("FAIL wide_hold q=%h want 3c", q8);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({q8, qn8} !== 16'hFF00) $display("FAIL wide_ff q/qn=%h/%h want ff/00", q8, qn8);
    else passed++;
    #4 reset8 = 1'b1;
    #0.1;
    total++;
    if ({q8, qn8} !== 16'hA55A) $display("FAIL wide_async q/qn=%h/%h want a5/5a", q8, qn8);
    else passed++;
  endtask

  initial begin
    reset1 = 1'b1; reset8 = 1'b1;
    d1 = 1'b1; d8 = 8'h00;
    #1;
    total++;
    if ({q1, qn1, q8, qn8} !== 18'b01_1010_0101_0101_1010)
      $display("FAIL reset_initial q1/qn1=%b%b q8/qn8=%h/%h want 01 a5/5a", q1, qn1, q8, qn8);
    else passed++;
    test_reset();
    test_capture();
    test_hold();
    test_async_reset();
    test_wide();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout after 50000 ns");
    $fatal(1);
  end
endmodule
